pingpong_game_ctrl: RTL and testbench
=====================================

// Module: pingpong_game_ctrl
// PURPOSE
//   Game core of the ping-pong box. Sits directly downstream of the clock divider
//   and consumes its two one-cycle pulses: tick_move (2 Hz) steps the ball and
//   tick_ms (1 kHz) paces button debouncing. Drives the LED ball row and both
//   score counters for the display stage.
// PARAMETERS
//   LED_NUM      8   number of LEDs in the ball row (>=3); pos 0 = left end
//   WIN_SCORE    7   points needed to win (1..15)
//   DEBOUNCE_MS  20  number of tick_ms pulses a raw button level must hold stable
// PORTS
//   clk        in   1        system clock (50 MHz)
//   rst        in   1        asynchronous active-low reset
//   tick_move  in   1        one-clk pulse, 2 Hz, ball step
//   tick_ms    in   1        one-clk pulse, 1 kHz, debounce sample
//   btn_l      in   1        raw left button, active-high, asynchronous
//   btn_r      in   1        raw right button, active-high, asynchronous
//   led        out  LED_NUM  ball display; led[pos] lit
//   score_l    out  4        left score, binary
//   score_r    out  4        right score, binary
//   winner     out  2        00 none, 01 left, 10 right
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, serve=left, pos=0, led=0, scores=0, winner=00,
//     debounce state cleared, stable=0.
//   Debounce (per button): 2-FF synchronizer -> sync. On tick_ms: if sync==stable
//     then cnt<=0, else cnt<=cnt+1; when cnt reaches DEBOUNCE_MS-1 with a tick,
//     stable<=sync and cnt<=0. press = one-clk pulse on a stable 0->1 transition.
//     Between tick_ms pulses, cnt holds.
//   FSM states: IDLE, MOVE_R, MOVE_L, POINT, OVER. led is registered (1 clk after state/pos).
//   IDLE: led = one-hot at server end (left: led[0], right: led[LED_NUM-1]).
//     Server press -> pos=server end, go to MOVE_R (left serve) or MOVE_L (right serve).
//     Non-server press is ignored.
//   MOVE_R: on tick_move: if pos==LED_NUM-1, left scores -> POINT; else pos<=pos+1.
//     btn_r press: if pos==LED_NUM-1, go to MOVE_L with pos unchanged (return);
//     otherwise (early hit) left scores -> POINT. btn_l press is ignored.
//   MOVE_L: mirror of MOVE_R (end = 0, pos decrements, btn_l returns, right scores on a miss).
//   Simultaneous press + tick_move in the same clk: press is evaluated first against
//     the current pos and the tick is discarded. A press at the end pos is a return,
//     even if that tick would have been a miss.
//   Simultaneous btn_l and btn_r presses: only the press relevant to the state acts.
//   Scoring: the scorer's score increments by 1 on POINT entry, saturating at WIN_SCORE.
//     serve <= the player who conceded.
//   POINT: led = all ones. Hold for 2 tick_move pulses (about 1 s), then go to OVER
//     if the scorer's score == WIN_SCORE, else go to IDLE. Presses are ignored.
//   OVER: winner set on entry. led toggles all-ones/all-zeros on each tick_move,
//     starting at all-ones. Any press clears scores and winner, serve=left -> IDLE.
//   Reset mid-rally or mid-debounce returns to reset state immediately. No tick is
//     buffered across reset.
// TESTING
//   1 Debounce: btn_l bounces 0/1 every 3 ms for 30 ms, then holds 1 -> exactly one
//     press, about 20 tick_ms pulses after the last edge; no press during bouncing.
//   2 Serve and miss, LED_NUM=8: left serves, 7 tick_move pulses move pos 0->7,
//     8th tick -> score_l=1, led=8'hFF for 2 ticks, then IDLE with right serving (led=8'h80).
//   3 Return: ball at pos 7 in MOVE_R, btn_r press -> MOVE_L; next tick -> led=8'h40.
//     Press on the same clk as the tick at pos 7 -> return, no point.
//   4 Early hit: btn_r press at pos 5 in MOVE_R -> score_l increments, POINT;
//     btn_l presses during MOVE_R are ignored.
//   5 Win: drive score_r to 6, then one more right point -> score_r=7, winner=10,
//     led blinks FF/00 per tick. Any press -> scores 0, IDLE with led=8'h01.
//   6 Assert rst low mid-rally (pos=4) -> led=0, scores=0, state IDLE asynchronously.

Source files
------------

// File: rtl/pingpong_game_ctrl_if.sv
// rtl/pingpong_game_ctrl_if.sv - tick, button and display signals of the ping-pong game core
interface pingpong_game_ctrl_if #(
    parameter int LED_NUM = 8
);
    logic               tick_move;
    logic               tick_ms;
    logic               btn_l;
    logic               btn_r;
    logic [LED_NUM-1:0] led;
    logic [3:0]         score_l;
    logic [3:0]         score_r;
    logic [1:0]         winner;

    modport master (
        output tick_move, tick_ms, btn_l, btn_r,
        input  led, score_l, score_r, winner
    );

    modport slave (
        input  tick_move, tick_ms, btn_l, btn_r,
        output led, score_l, score_r, winner
    );
endinterface

// File: rtl/pingpong_game_ctrl.sv
// rtl/pingpong_game_ctrl.sv - ping-pong game core: button debounce, rally FSM, scoring and LED row
module pingpong_game_ctrl #(
    parameter int LED_NUM     = 8,
    parameter int WIN_SCORE   = 7,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    pingpong_game_ctrl_if.slave  io
);
    localparam int                 CW      = $clog2(DEBOUNCE_MS + 1);
    localparam int                 PW      = $clog2(LED_NUM);
    localparam logic [PW-1:0]      POS_R   = PW'(LED_NUM - 1);
    localparam logic [3:0]         WIN     = 4'(WIN_SCORE);
    localparam logic [LED_NUM-1:0] LED_ONE = LED_NUM'(1);
    localparam logic [CW-1:0]      CNT_TOP = CW'(DEBOUNCE_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_R,
        S_MOVE_L,
        S_POINT,
        S_OVER
    } state_t;

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]    btn_raw;
    logic [1:0]    meta_q;
    logic [1:0]    sync_q;
    logic [1:0]    stable_q;
    logic [1:0]    press_q;
    logic [CW-1:0] cnt_q [2];

    assign btn_raw = {io.btn_r, io.btn_l};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            press_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            meta_q  <= btn_raw;
            sync_q  <= meta_q;
            press_q <= '0;
            for (int b = 0; b < 2; b++) begin
                if (io.tick_ms) begin
                    if (sync_q[b] == stable_q[b]) begin
                        cnt_q[b] <= '0;
                    end else if (cnt_q[b] == CNT_TOP) begin
                        stable_q[b] <= sync_q[b];
                        cnt_q[b]    <= '0;
                        press_q[b]  <= sync_q[b];
                    end else begin
                        cnt_q[b] <= cnt_q[b] + CW'(1);
                    end
                end
            end
        end
    end

    logic press_l;
    logic press_r;
    assign press_l = press_q[0];
    assign press_r = press_q[1];

    state_t             state_q;
    logic [PW-1:0]      pos_q;
    logic               serve_q;
    logic               scorer_q;
    logic               hold_q;
    logic               blink_q;
    logic [3:0]         score_l_q;
    logic [3:0]         score_r_q;
    logic [1:0]         winner_q;
    logic [LED_NUM-1:0] led_q;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : s + 4'd1;
    endfunction

    // A press is judged against the current pos before any tick in the same cycle.
    logic left_scores;
    logic right_scores;
    logic scorer_won;

    always_comb begin
        left_scores  = 1'b0;
        right_scores = 1'b0;
        if (state_q == S_MOVE_R) begin
            left_scores = press_r ? (pos_q != POS_R) : (io.tick_move && (pos_q == POS_R));
        end
        if (state_q == S_MOVE_L) begin
            right_scores = press_l ? (pos_q != '0) : (io.tick_move && (pos_q == '0));
        end
        scorer_won = scorer_q ? (score_r_q == WIN) : (score_l_q == WIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            serve_q   <= 1'b0;
            scorer_q  <= 1'b0;
            hold_q    <= 1'b0;
            blink_q   <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            led_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!serve_q && press_l) begin
                        pos_q   <= '0;
                        state_q <= S_MOVE_R;
                    end else if (serve_q && press_r) begin
                        pos_q   <= POS_R;
                        state_q <= S_MOVE_L;
                    end
                end
                S_MOVE_R: begin
                    if (left_scores) begin
                        score_l_q <= sat_inc(score_l_q);
                        scorer_q  <= 1'b0;
                        serve_q   <= 1'b1;
                        hold_q    <= 1'b0;
                        state_q   <= S_POINT;
                    end else if (press_r) begin
                        state_q <= S_MOVE_L;
                    end else if (io.tick_move) begin
                        pos_q <= pos_q + PW'(1);
                    end
                end
                S_MOVE_L: begin
                    if (right_scores) begin
                        score_r_q <= sat_inc(score_r_q);
                        scorer_q  <= 1'b1;
                        serve_q   <= 1'b0;
                        hold_q    <= 1'b0;
                        state_q   <= S_POINT;
                    end else if (press_l) begin
                        state_q <= S_MOVE_R;
                    end else if (io.tick_move) begin
                        pos_q <= pos_q - PW'(1);
                    end
                end
                S_POINT: begin
                    if (io.tick_move) begin
                        if (!hold_q) begin
                            hold_q <= 1'b1;
                        end else if (scorer_won) begin
                            winner_q <= scorer_q ? 2'b10 : 2'b01;
                            blink_q  <= 1'b1;
                            state_q  <= S_OVER;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_OVER: begin
                    if (press_l || press_r) begin
                        score_l_q <= '0;
                        score_r_q <= '0;
                        winner_q  <= 2'b00;
                        serve_q   <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (io.tick_move) begin
                        blink_q <= !blink_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // The LED row trails the state and pos registers by one clock.
            case (state_q)
                S_IDLE:   led_q <= serve_q ? (LED_ONE << POS_R) : LED_ONE;
                S_MOVE_R,
                S_MOVE_L: led_q <= LED_ONE << pos_q;
                S_POINT:  led_q <= '1;
                S_OVER:   led_q <= blink_q ? '1 : '0;
                default:  led_q <= '0;
            endcase
        end
    end

    assign io.led     = led_q;
    assign io.score_l = score_l_q;
    assign io.score_r = score_r_q;
    assign io.winner  = winner_q;
endmodule

// File: tb/tb_pingpong_game_ctrl.sv
// tb/tb_pingpong_game_ctrl.sv - directed bench for pingpong_game_ctrl with hand-computed expectations
module tb_pingpong_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    pingpong_game_ctrl_if #(.LED_NUM(8)) io ();

    pingpong_game_ctrl #(
        .LED_NUM    (8),
        .WIN_SCORE  (7),
        .DEBOUNCE_MS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ms_ticks(input int n);
        repeat (n) begin
            @(negedge clk); io.tick_ms = 1'b1;
            @(negedge clk); io.tick_ms = 1'b0;
        end
    endtask

    task automatic tick_mv(input int n);
        repeat (n) begin
            @(negedge clk); io.tick_move = 1'b1;
            @(negedge clk); io.tick_move = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic set_btn(input bit is_r, input logic v);
        if (is_r) io.btn_r = v;
        else      io.btn_l = v;
    endtask

    // Holds a button through a full debounce; with_tick lands tick_move on the
    // same clock the FSM first sees the press.
    task automatic press_btn(input bit is_r, input bit with_tick);
        @(negedge clk); set_btn(is_r, 1'b1);
        repeat (3) @(negedge clk);
        ms_ticks(19);
        @(negedge clk); io.tick_ms = 1'b1;
        @(negedge clk); io.tick_ms = 1'b0; io.tick_move = with_tick;
        @(negedge clk); io.tick_move = 1'b0;
        repeat (2) @(negedge clk);
        set_btn(is_r, 1'b0);
        repeat (3) @(negedge clk);
        ms_ticks(20);
        repeat (2) @(negedge clk);
    endtask

    // From IDLE with left serving: serve, right returns at the end, left hits early.
    task automatic right_point_no_hold();
        press_btn(1'b0, 1'b0);
        tick_mv(7);
        press_btn(1'b1, 1'b0);
        press_btn(1'b0, 1'b0);
    endtask

    initial begin
        io.tick_move = 1'b0;
        io.tick_ms   = 1'b0;
        io.btn_l     = 1'b0;
        io.btn_r     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", 32'(io.led), 32'h00);
        check("reset_score_l", 32'(io.score_l), 32'd0);
        check("reset_winner", 32'(io.winner), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_left_serve", 32'(io.led), 32'h01);

        // Bouncing left button must not serve.
        for (int k = 0; k < 10; k++) begin
            io.btn_l = (k % 2 == 0);
            ms_ticks(3);
        end
        tick_mv(1);
        check("bounce_no_press", 32'(io.led), 32'h01);
        io.btn_l = 1'b1;
        repeat (3) @(negedge clk);
        ms_ticks(19);
        tick_mv(1);
        check("debounce_19_no_press", 32'(io.led), 32'h01);
        ms_ticks(1);
        repeat (2) @(negedge clk);
        tick_mv(1);
        check("debounce_20_serve", 32'(io.led), 32'h02);
        io.btn_l = 1'b0;
        repeat (3) @(negedge clk);
        ms_ticks(20);
        repeat (2) @(negedge clk);

        // Serve and miss at the right end.
        tick_mv(6);
        check("move_pos7", 32'(io.led), 32'h80);
        tick_mv(1);
        check("miss_score_l", 32'(io.score_l), 32'd1);
        check("point_led", 32'(io.led), 32'hFF);
        tick_mv(1);
        check("point_hold", 32'(io.led), 32'hFF);
        tick_mv(1);
        check("idle_right_serve", 32'(io.led), 32'h80);

        // Right serves, returns at both ends including press+tick collisions.
        press_btn(1'b1, 1'b0);
        check("serve_r_led", 32'(io.led), 32'h80);
        tick_mv(7);
        check("movel_pos0", 32'(io.led), 32'h01);
        press_btn(1'b0, 1'b1);
        check("sim_ret_l_nopoint", 32'(io.score_r), 32'd0);
        tick_mv(1);
        check("after_ret_l", 32'(io.led), 32'h02);
        tick_mv(6);
        check("mover_pos7", 32'(io.led), 32'h80);
        press_btn(1'b1, 1'b1);
        check("sim_ret_r_nopoint", 32'(io.score_l), 32'd1);
        tick_mv(1);
        check("after_ret_r", 32'(io.led), 32'h40);

        // Early hit, and left presses ignored during MOVE_R.
        tick_mv(6);
        press_btn(1'b0, 1'b0);
        press_btn(1'b0, 1'b0);
        tick_mv(1);
        check("btn_l_ignored", 32'(io.led), 32'h02);
        tick_mv(4);
        check("mover_pos5", 32'(io.led), 32'h20);
        press_btn(1'b1, 1'b0);
        check("early_hit_score", 32'(io.score_l), 32'd2);
        check("early_hit_led", 32'(io.led), 32'hFF);
        tick_mv(2);
        check("early_hit_idle", 32'(io.led), 32'h80);

        // Right climbs to the winning score.
        press_btn(1'b1, 1'b0);
        press_btn(1'b0, 1'b0);
        tick_mv(2);
        check("right_first_point", 32'(io.score_r), 32'd1);
        check("serve_back_left", 32'(io.led), 32'h01);
        for (int p = 0; p < 5; p++) begin
            right_point_no_hold();
            tick_mv(2);
        end
        check("score_r_six", 32'(io.score_r), 32'd6);
        check("no_winner_yet", 32'(io.winner), 32'd0);
        right_point_no_hold();
        check("win_score", 32'(io.score_r), 32'd7);
        tick_mv(2);
        check("winner_right", 32'(io.winner), 32'd2);
        check("over_blink_on", 32'(io.led), 32'hFF);
        tick_mv(1);
        check("over_blink_off", 32'(io.led), 32'h00);
        tick_mv(1);
        check("over_blink_on2", 32'(io.led), 32'hFF);
        press_btn(1'b1, 1'b0);
        check("over_exit_led", 32'(io.led), 32'h01);
        check("over_exit_score_l", 32'(io.score_l), 32'd0);
        check("over_exit_score_r", 32'(io.score_r), 32'd0);
        check("over_exit_winner", 32'(io.winner), 32'd0);

        // Asynchronous reset mid-rally.
        press_btn(1'b0, 1'b0);
        press_btn(1'b1, 1'b0);
        tick_mv(2);
        press_btn(1'b1, 1'b0);
        tick_mv(3);
        check("rally_pos4", 32'(io.led), 32'h10);
        check("rally_score_l", 32'(io.score_l), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("async_rst_led", 32'(io.led), 32'h00);
        check("async_rst_score", 32'(io.score_l), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(io.led), 32'h01);
        tick_mv(1);
        check("post_rst_tick_ignored", 32'(io.led), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
